mem_access_unit: RTL

- Memory access sequencer that sits directly downstream of the multicycle control unit, between that unit's memory strobes (IouD, EscreveMem, EscreveIR, EscreveMDR) and the synchronous instruction/data memory.
- Selects the address (PC or ALUOut), issues read/write cycles to memory and counts the memory read latency.
- Captures read data into the Instruction Register or the Memory Data Register.
- Reports completion with a one-cycle done pulse and flags misaligned word accesses.

---
 rtl/mem_access_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Sequences single read/write cycles between the multicycle control unit and synchronous memory; reads take READ_LATENCY cycles, writes one.
// No backpressure: requests are sampled only in IDLE and ignored while busy, so the requester waits for done.
module mem_access_unit #(
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              IouD,
    input  logic              dst_ir,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              done,
    output logic              err,
    output logic              misalign_sticky,
    output logic              busy,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } stateT;

    localparam logic [3:0] RD_INIT = 4'(READ_LATENCY - 1);

    stateT             stateQ;
    logic [3:0]        rdCount;
    logic              dstIrQ;
    logic [DATA_W-1:0] selAddr;
    logic              misaligned;

    assign selAddr    = IouD ? alu_out : pc;
    assign misaligned = (selAddr[1:0] != 2'b00);
    assign busy       = (stateQ != IDLE);
    assign state      = stateQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ          <= IDLE;
            rdCount         <= 4'd0;
            dstIrQ          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_en          <= 1'b0;
            mem_we          <= 1'b0;
            ir              <= '0;
            mdr             <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            misalign_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (req_wr || req_rd) begin
                        if (misaligned) begin
                            // Rejected without touching memory; reported like a completion.
                            done            <= 1'b1;
                            err             <= 1'b1;
                            misalign_sticky <= 1'b1;
                        end else begin
                            mem_addr <= selAddr;
                            mem_en   <= 1'b1;
                            if (req_wr) begin
                                mem_wdata <= wdata;
                                mem_we    <= 1'b1;
                                stateQ    <= WR;
                            end else begin
                                mem_we  <= 1'b0;
                                dstIrQ  <= dst_ir;
                                rdCount <= RD_INIT;
                                stateQ  <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (rdCount != 4'd0) begin
                        rdCount <= rdCount - 4'd1;
                    end else begin
                        if (dstIrQ) begin
                            ir <= mem_rdata;
                        end else begin
                            mdr <= mem_rdata;
                        end
                        mem_en <= 1'b0;
                        done   <= 1'b1;
                        stateQ <= IDLE;
                    end
                end
                WR: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    stateQ <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    stateQ <= IDLE;
                end
            endcase
        end
    end

endmodule
